// File: rtl/sdr_16_responder_pkg.sv
// sdr_16_responder_pkg: command encodings, mode-register fields, error codes and burst helpers
package sdr_16_responder_pkg;

   typedef enum logic [2:0] {
      CMD_LMR = 3'b000,
      CMD_RFR = 3'b001,
      CMD_PCH = 3'b010,
      CMD_ACT = 3'b011,
      CMD_WR  = 3'b100,
      CMD_RD  = 3'b101,
      CMD_BST = 3'b110,
      CMD_NOP = 3'b111
   } cmd_t;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_ACT_OPEN = 3'd1;
   localparam logic [2:0] ERR_CLOSED   = 3'd2;
   localparam logic [2:0] ERR_RFR_OPEN = 3'd3;
   localparam logic [2:0] ERR_NO_LMR   = 3'd4;
   localparam logic [2:0] ERR_LMR_OPEN = 3'd5;

   function automatic logic [3:0] bl_decode(input logic [2:0] f);
      return f == 3'd0 ? 4'd1 : f == 3'd1 ? 4'd2 : f == 3'd2 ? 4'd4 : 4'd8;
   endfunction

   // Low log2(BL) bits wrap inside the BL-aligned block; upper bits are held
   function automatic logic [9:0] burst_col(input logic [9:0] s, input logic [2:0] k,
                                            input logic [3:0] bl, input logic bt);
      logic [9:0] m;
      logic [9:0] lo;
      m  = {6'd0, bl - 4'd1};
      lo = bt ? (s ^ {7'd0, k}) : (s + {7'd0, k});
      return (s & ~m) | (lo & m);
   endfunction

endpackage

// File: rtl/sdr_16_resp_ram.sv
// sdr_16_resp_ram: 1W1R synchronous RAM, 16-bit words, per-byte write enable, registered read
module sdr_16_resp_ram #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic [1:0]    we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata
);

   logic [15:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we[0]) mem[waddr][7:0] <= wdata[7:0];
      if (we[1]) mem[waddr][15:8] <= wdata[15:8];
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/sdr_16_responder.sv
// sdr_16_responder: SDR SDRAM device model (16-bit) with bank table, CL read pipe and burst engine.
// Optional protocol checker enabled by defining SDR_RESP_CHECK_EN.
module sdr_16_responder
   import sdr_16_responder_pkg::*;
#(
   parameter int ROW_SIZE     = 13,
   parameter int COL_SIZE     = 9,
   parameter int MEM_ROW_BITS = 4,
   parameter int MEM_COL_BITS = 6
) (
   input  logic                sdram_clk,
   input  logic                sdram_rst_n,
   input  logic [1:0]          ba,
   input  logic [ROW_SIZE-1:0] a,
   input  logic [2:0]          cmd,
   input  logic [1:0]          dqm,
   input  logic [15:0]         dq_i,
   output logic [15:0]         dq_o,
   output logic                dq_oe,
   output logic                err_o,
   output logic [2:0]          err_code
);

   localparam int AW = 2 + MEM_ROW_BITS + MEM_COL_BITS;

   cmd_t                    c;
   logic [3:0]              open_ba;
   logic [ROW_SIZE-1:0]     open_row [4];
   logic [7:0]              mode;
   logic                    mode_valid;
   logic                    bst_act, bst_wr;
   logic [1:0]              bst_ba;
   logic [MEM_ROW_BITS-1:0] bst_row;
   logic [9:0]              bst_col;
   logic [2:0]              bst_k, bst_last;
   logic                    rv, p1_v, blank;
   logic [15:0]             p1_d, ram_q;

   logic                    is_rw, cl2, pch_hit, cont, beat, beat_wr, src_v;
   logic [3:0]              bl, blm1;
   logic [2:0]              len_m1;
   logic [9:0]              a_col, b_col;
   logic [MEM_ROW_BITS-1:0] a_row, b_row;
   logic [1:0]              b_ba, we;
   logic [AW-1:0]           addr;
   logic [15:0]             src_d;

   assign c       = cmd_t'(cmd);
   assign is_rw   = c == CMD_RD || c == CMD_WR;
   assign bl      = bl_decode(mode[2:0]);
   assign blm1    = bl - 4'd1;
   assign cl2     = mode[6:4] == 3'd2;
   assign len_m1  = (c == CMD_WR && mode[7]) ? 3'd0 : blm1[2:0];
   assign a_col   = 10'(a[COL_SIZE-1:0]);
   assign a_row   = open_ba[ba] ? open_row[ba][MEM_ROW_BITS-1:0] : '0;
   assign pch_hit = c == CMD_PCH && (a[10] || ba == bst_ba);
   assign cont    = bst_act && !is_rw && !pch_hit;
   assign beat    = is_rw || cont;
   assign beat_wr = is_rw ? c == CMD_WR : bst_wr;
   assign b_ba    = is_rw ? ba : bst_ba;
   assign b_row   = is_rw ? a_row : bst_row;
   assign b_col   = is_rw ? a_col : burst_col(bst_col, bst_k, bl, mode[3]);
   assign addr    = {b_ba, b_row, b_col[MEM_COL_BITS-1:0]};
   assign we      = (beat && beat_wr) ? ~dqm : 2'b00;
   // CL2 takes the RAM output straight into dq_o; CL3 adds one stage
   assign src_v   = cl2 ? rv : p1_v;
   assign src_d   = cl2 ? ram_q : p1_d;

   sdr_16_resp_ram #(.AW(AW)) u_ram (
      .clk   (sdram_clk),
      .we    (we),
      .waddr (addr),
      .wdata (dq_i),
      .raddr (addr),
      .rdata (ram_q)
   );

   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) begin
         open_ba    <= '0;
         for (int i = 0; i < 4; i++) open_row[i] <= '0;
         mode       <= '0;
         mode_valid <= 1'b0;
         bst_act    <= 1'b0;
         bst_wr     <= 1'b0;
         bst_ba     <= '0;
         bst_row    <= '0;
         bst_col    <= '0;
         bst_k      <= '0;
         bst_last   <= '0;
         rv         <= 1'b0;
         p1_v       <= 1'b0;
         p1_d       <= '0;
         blank      <= 1'b0;
         dq_o       <= '0;
         dq_oe      <= 1'b0;
      end else begin
         if (c == CMD_LMR) begin
            mode       <= {a[9], a[6:0]};
            mode_valid <= 1'b1;
         end
         if (c == CMD_ACT) begin
            open_ba[ba]  <= 1'b1;
            open_row[ba] <= a;
         end
         if (c == CMD_PCH) open_ba <= a[10] ? 4'b0 : open_ba & ~(4'b1 << ba);
         if (is_rw) begin
            bst_act  <= len_m1 != 3'd0;
            bst_wr   <= c == CMD_WR;
            bst_ba   <= ba;
            bst_row  <= a_row;
            bst_col  <= a_col;
            bst_k    <= 3'd1;
            bst_last <= len_m1;
         end else if (cont) begin
            bst_act <= bst_k != bst_last;
            bst_k   <= bst_k + 3'd1;
         end else begin
            bst_act <= 1'b0;
         end
         rv    <= beat && !beat_wr;
         blank <= |dqm;
         p1_v  <= rv && c != CMD_WR;
         p1_d  <= ram_q;
         dq_oe <= src_v && !blank && c != CMD_WR;
         dq_o  <= (src_v && !blank && c != CMD_WR) ? src_d : '0;
      end
   end

`ifdef SDR_RESP_CHECK_EN
   logic [2:0] code;

   assign code = ((c == CMD_ACT || is_rw) && !mode_valid) ? ERR_NO_LMR :
                 (c == CMD_ACT && open_ba[ba])            ? ERR_ACT_OPEN :
                 (is_rw && !open_ba[ba])                  ? ERR_CLOSED :
                 (c == CMD_RFR && |open_ba)               ? ERR_RFR_OPEN :
                 (c == CMD_LMR && |open_ba)               ? ERR_LMR_OPEN : ERR_NONE;

   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) begin
         err_o    <= 1'b0;
         err_code <= '0;
      end else if (!err_o && code != ERR_NONE) begin
         err_o    <= 1'b1;
         err_code <= code;
      end
   end
`else
   assign err_o    = 1'b0;
   assign err_code = 3'd0;
`endif

endmodule
